// File: rtl/word_serializer_if.sv
// Handshake and serial-output bundle for word_serializer.
interface word_serializer_if;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, tx_o, busy_o, done_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, tx_o, busy_o, done_o
  );
endinterface

// File: rtl/word_serializer.sv
// Serializes one accepted 32-bit word as start bit, 32 data bits LSB-first, stop bit;
// each bit is held for CLKS_PER_BIT clock cycles.
module word_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  word_serializer_if.slave   bus
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [4:0]    idx_q,   idx_d;
  logic          tx_q,    tx_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          ready;
  logic          bit_end;

  assign ready   = (state_q == IDLE) && !rst_i;
  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_i && ready) begin
          shreg_d = bus.data_i;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 5'd1;
          if (idx_q == 5'd31) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state so they land in the same cycle as the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shreg_d[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.tx_o    = tx_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: four serializers (CLKS_PER_BIT = 1..4) checked against a frame-timing model.
module tb_word_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] data_a  [4];
  logic        valid_a [4];
  logic        ready_a [4];
  logic        tx_a    [4];
  logic        busy_a  [4];
  logic        done_a  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    word_serializer_if bus ();
    assign bus.data_i  = data_a[g];
    assign bus.valid_i = valid_a[g];
    assign ready_a[g]  = bus.ready_o;
    assign tx_a[g]     = bus.tx_o;
    assign busy_a[g]   = bus.busy_o;
    assign done_a[g]   = bus.done_o;
    word_serializer #(.CLKS_PER_BIT(g + 1)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
  end

  int total = 0;
  int bad   = 0;

  logic tx_s    [512];
  logic busy_s  [512];
  logic done_s  [512];
  logic ready_s [512];

  // Expected line level in cycle k (k=1 is the cycle after the acceptance edge).
  function automatic logic exp_tx(input logic [31:0] w, input int n, input int k);
    int i;
    if (k >= 1 && k <= n) return 1'b0;
    if (k > n && k <= 33 * n) begin
      i = (k - 1) / n - 1;
      return w[i];
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int n, input int k);
    return (k >= 1 && k <= 34 * n);
  endfunction

  // Drive a word and wait (bounded) for the acceptance edge; returns just after that edge.
  task automatic accept(input int idx, input logic [31:0] w, output bit ok);
    ok = 1'b0;
    data_a[idx]  = w;
    valid_a[idx] = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (ready_a[idx] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout inst=%0d got ready=%b want 1", idx, ready_a[idx]);
      valid_a[idx] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Record outputs for cycles 1..len; valid is held through cycle valid_until, or randomized if toggle.
  task automatic capture(input int idx, input int len, input int valid_until,
                         input logic [31:0] next_data, input bit toggle);
    for (int k = 1; k <= len; k++) begin
      if (toggle) begin
        data_a[idx]  = '1;
        valid_a[idx] = (k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        if (k == 1) data_a[idx] = next_data;
        valid_a[idx] = (k <= valid_until);
      end
      @(negedge clk);
      tx_s[k]    = tx_a[idx];
      busy_s[k]  = busy_a[idx];
      done_s[k]  = done_a[idx];
      ready_s[k] = ready_a[idx];
      @(posedge clk);
      #1;
    end
    valid_a[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({tx_a[i], busy_a[i], done_a[i], ready_a[i]} !== 4'b1000) begin
          bad++;
          $display("FAIL reset_hold inst=%0d got tx/busy/done/ready=%b%b%b%b want 1000",
                   i, tx_a[i], busy_a[i], done_a[i], ready_a[i]);
        end
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({tx_a[i], busy_a[i], done_a[i], ready_a[i]} !== 4'b1001) begin
          bad++;
          $display("FAIL reset_idle inst=%0d got tx/busy/done/ready=%b%b%b%b want 1001",
                   i, tx_a[i], busy_a[i], done_a[i], ready_a[i]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single_n2();
    bit ok;
    accept(1, 32'h0000_0001, ok);
    capture(1, 69, 0, 32'h0000_0001, 1'b0);
    for (int k = 1; k <= 69; k++) begin
      total++;
      if (tx_s[k] !== exp_tx(32'h1, 2, k)) begin
        bad++;
        $display("FAIL n2_tx cycle=%0d got %b want %b", k, tx_s[k], exp_tx(32'h1, 2, k));
      end
      total++;
      if (busy_s[k] !== exp_busy(2, k) || done_s[k] !== (k == 69) || ready_s[k] !== (k == 69)) begin
        bad++;
        $display("FAIL n2_ctrl cycle=%0d got busy/done/ready=%b%b%b want %b%b%b",
                 k, busy_s[k], done_s[k], ready_s[k], exp_busy(2, k), k == 69, k == 69);
      end
    end
  endtask

  task automatic test_n1_pattern();
    bit ok;
    logic [31:0] word;
    accept(0, 32'hA5A5_5A5A, ok);
    capture(0, 35, 0, 32'hA5A5_5A5A, 1'b0);
    for (int i = 0; i < 32; i++) word[i] = tx_s[i + 2];
    total++;
    if (word !== 32'hA5A5_5A5A) begin
      bad++;
      $display("FAIL n1_word got %h want a5a55a5a", word);
    end
    total++;
    if (tx_s[1] !== 1'b0 || tx_s[34] !== 1'b1) begin
      bad++;
      $display("FAIL n1_framing got start=%b stop=%b want 0 1", tx_s[1], tx_s[34]);
    end
    total++;
    if (done_s[35] !== 1'b1 || done_s[34] !== 1'b0) begin
      bad++;
      $display("FAIL n1_done got c34=%b c35=%b want 0 1", done_s[34], done_s[35]);
    end
  endtask

  task automatic test_data_stability();
    bit ok;
    logic [31:0] word;
    int early;
    accept(3, 32'hDEAD_BEEF, ok);
    capture(3, 137, 0, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 32; i++) word[i] = tx_s[(i + 2) * 4];
    total++;
    if (word !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL stable_word got %h want deadbeef", word);
    end
    early = 0;
    for (int k = 1; k <= 136; k++) if (ready_s[k] !== 1'b0 || busy_s[k] !== 1'b1 || done_s[k] !== 1'b0) early++;
    total++;
    if (early !== 0) begin
      bad++;
      $display("FAIL stable_no_reaccept got %0d disturbed cycles want 0", early);
    end
    total++;
    if (done_s[137] !== 1'b1) begin
      bad++;
      $display("FAIL stable_done got %b want 1", done_s[137]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] w1, w2, word;
    int dpos[$];
    w1 = 32'h1234_5678;
    w2 = 32'h8765_4321;
    accept(2, w1, ok);
    capture(2, 206, 103, w2, 1'b0);
    for (int k = 1; k <= 206; k++) begin
      total++;
      if (tx_s[k] !== ((k <= 103) ? exp_tx(w1, 3, k) : exp_tx(w2, 3, k - 103))) begin
        bad++;
        $display("FAIL b2b_tx cycle=%0d got %b", k, tx_s[k]);
      end
      if (done_s[k] === 1'b1) dpos.push_back(k);
    end
    total++;
    if (dpos.size() != 2 || dpos[0] != 103 || dpos[1] != 206) begin
      bad++;
      $display("FAIL b2b_done got %0d pulses first=%0d want 2 at 103 and 206",
               dpos.size(), (dpos.size() > 0) ? dpos[0] : -1);
    end
    for (int i = 0; i < 32; i++) word[i] = tx_s[(i + 2) * 3 + 103];
    total++;
    if (word !== w2) begin
      bad++;
      $display("FAIL b2b_word2 got %h want %h", word, w2);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int dcount;
    accept(1, 32'hFFFF_0000, ok);
    capture(1, 22, 0, 32'hFFFF_0000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx_a[1] !== 1'b0 || busy_a[1] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_bit10 got tx=%b busy=%b want 0 1", tx_a[1], busy_a[1]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({tx_a[1], busy_a[1], ready_a[1], done_a[1]} !== 4'b1010) begin
      bad++;
      $display("FAIL midrst_after got tx/busy/ready/done=%b%b%b%b want 1010",
               tx_a[1], busy_a[1], ready_a[1], done_a[1]);
    end
    dcount = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done_a[1] === 1'b1 || tx_a[1] !== 1'b1) dcount++;
    end
    total++;
    if (dcount !== 0) begin
      bad++;
      $display("FAIL midrst_quiet got %0d active cycles want 0", dcount);
    end
    accept(1, 32'h0000_FFFF, ok);
    capture(1, 69, 0, 32'h0000_FFFF, 1'b0);
    for (int k = 1; k <= 69; k++) begin
      total++;
      if (tx_s[k] !== exp_tx(32'h0000_FFFF, 2, k) || done_s[k] !== (k == 69)) begin
        bad++;
        $display("FAIL midrst_next cycle=%0d got tx=%b done=%b want %b %b",
                 k, tx_s[k], done_s[k], exp_tx(32'h0000_FFFF, 2, k), k == 69);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int idx, n, len;
    logic [31:0] w;
    for (int r = 0; r < 8; r++) begin
      idx = $urandom_range(0, 3);
      n   = idx + 1;
      len = 34 * n + 1;
      w   = $urandom;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      accept(idx, w, ok);
      capture(idx, len, 0, w, 1'b0);
      for (int k = 1; k <= len; k++) begin
        total++;
        if (tx_s[k] !== exp_tx(w, n, k) || busy_s[k] !== exp_busy(n, k) || done_s[k] !== (k == len)) begin
          bad++;
          $display("FAIL rand_frame n=%0d w=%h cycle=%0d got tx/busy/done=%b%b%b want %b%b%b",
                   n, w, k, tx_s[k], busy_s[k], done_s[k], exp_tx(w, n, k), exp_busy(n, k), k == len);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      data_a[i]  = '0;
      valid_a[i] = 1'b0;
    end
    test_reset();
    test_single_n2();
    test_n1_pattern();
    test_data_stability();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
